// File: rtl/ram_access_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : ram_access_arbiter_if
// Brief    : Requester and RAM-side bus bundle for ram_access_arbiter.
//            The slave modport is the arbiter's view. The master modport is
//            the environment's view (requesters plus RAM).
// Revision : 1.0 - initial release
// ============================================================================
interface ram_access_arbiter_if #(
  parameter int ADDR_SIZE = 8
);
  // Port 0 (SPI slave path)
  logic                 req0_valid;
  logic                 req0_we;
  logic [ADDR_SIZE-1:0] req0_addr;
  logic [ADDR_SIZE-1:0] req0_wdata;
  logic                 req0_ready;
  logic                 rsp0_valid;
  logic [ADDR_SIZE-1:0] rsp0_rdata;
  logic                 rsp0_err;

  // Port 1 (local host)
  logic                 req1_valid;
  logic                 req1_we;
  logic [ADDR_SIZE-1:0] req1_addr;
  logic [ADDR_SIZE-1:0] req1_wdata;
  logic                 req1_ready;
  logic                 rsp1_valid;
  logic [ADDR_SIZE-1:0] rsp1_rdata;
  logic                 rsp1_err;

  // RAM command/response pins
  logic [ADDR_SIZE+1:0] ram_din;
  logic                 ram_rx_valid;
  logic [ADDR_SIZE-1:0] ram_dout;
  logic                 ram_tx_valid;

  logic                 busy;

  modport slave (
    input  req0_valid, req0_we, req0_addr, req0_wdata,
    output req0_ready, rsp0_valid, rsp0_rdata, rsp0_err,
    input  req1_valid, req1_we, req1_addr, req1_wdata,
    output req1_ready, rsp1_valid, rsp1_rdata, rsp1_err,
    output ram_din, ram_rx_valid,
    input  ram_dout, ram_tx_valid,
    output busy
  );

  modport master (
    output req0_valid, req0_we, req0_addr, req0_wdata,
    input  req0_ready, rsp0_valid, rsp0_rdata, rsp0_err,
    output req1_valid, req1_we, req1_addr, req1_wdata,
    input  req1_ready, rsp1_valid, rsp1_rdata, rsp1_err,
    input  ram_din, ram_rx_valid,
    output ram_dout, ram_tx_valid,
    input  busy
  );
endinterface
`default_nettype wire

// File: rtl/ram_access_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ram_access_arbiter
// Brief    : Round-robin arbiter that shares a single-port RAM between two
//            requesters. It serialises each granted access into the RAM's
//            two-word command stream and, for reads, waits for the returned
//            byte. A bounded wait produces an error response.
// Revision : 1.0 - initial release
// ============================================================================
module ram_access_arbiter #(
  parameter int ADDR_SIZE = 8,
  parameter int TIMEOUT   = 15,
  parameter int TO_W      = 4
) (
  input  wire logic           clk,
  input  wire logic           rst_n,
  ram_access_arbiter_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_CMD_ADDR = 3'd1,
    S_CMD_DATA = 3'd2,
    S_WAIT_TX  = 3'd3,
    S_RESP     = 3'd4
  } state_t;

  localparam logic [1:0]           c_op_waddr  = 2'b00;
  localparam logic [1:0]           c_op_wdata  = 2'b01;
  localparam logic [1:0]           c_op_raddr  = 2'b10;
  localparam logic [1:0]           c_op_rdummy = 2'b11;
  localparam logic [ADDR_SIZE-1:0] c_zero      = {ADDR_SIZE{1'b0}};
  // The last count value at which the wait is abandoned. Counting starts at 0,
  // so exactly TIMEOUT cycles are spent in WAIT_TX.
  localparam logic [TO_W-1:0]      c_to_last   = TO_W'(TIMEOUT - 1);

  state_t               r_state;
  logic                 r_rr_ptr;
  logic                 r_owner;
  logic                 r_we;
  logic [ADDR_SIZE-1:0] r_wdata;
  logic [TO_W-1:0]      r_to_cnt;
  logic [ADDR_SIZE+1:0] r_ram_din;
  logic                 r_ram_rx_valid;
  logic                 r_rsp0_valid;
  logic                 r_rsp1_valid;
  logic [ADDR_SIZE-1:0] r_rsp0_rdata;
  logic [ADDR_SIZE-1:0] r_rsp1_rdata;
  logic                 r_rsp0_err;
  logic                 r_rsp1_err;

  logic                 w_idle;
  logic                 w_grant0;
  logic                 w_grant1;
  logic                 w_sel_we;
  logic [ADDR_SIZE-1:0] w_sel_addr;
  logic [ADDR_SIZE-1:0] w_sel_wdata;
  logic                 w_wait_to;
  logic                 w_done;
  logic [ADDR_SIZE-1:0] w_done_rdata;
  logic                 w_done_err;

  // A lone requester always wins. On a tie, r_rr_ptr names the winner.
  assign w_idle      = (r_state == S_IDLE);
  assign w_grant0    = w_idle && bus.req0_valid && (!bus.req1_valid || !r_rr_ptr);
  assign w_grant1    = w_idle && bus.req1_valid && (!bus.req0_valid ||  r_rr_ptr);
  assign w_sel_we    = w_grant1 ? bus.req1_we    : bus.req0_we;
  assign w_sel_addr  = w_grant1 ? bus.req1_addr  : bus.req0_addr;
  assign w_sel_wdata = w_grant1 ? bus.req1_wdata : bus.req0_wdata;

  // A transaction completes when a write finishes its data strobe, or when a
  // read either receives its byte or exhausts the wait budget.
  assign w_wait_to    = (r_state == S_WAIT_TX) && !bus.ram_tx_valid && (r_to_cnt == c_to_last);
  assign w_done       = ((r_state == S_CMD_DATA) && r_we) ||
                        ((r_state == S_WAIT_TX) && (bus.ram_tx_valid || w_wait_to));
  assign w_done_rdata = ((r_state == S_WAIT_TX) && bus.ram_tx_valid) ? bus.ram_dout : c_zero;
  assign w_done_err   = w_wait_to;

  // Transaction sequencer: the grant, the command stream, the read wait and the registered responses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= S_IDLE;
      r_rr_ptr       <= 1'b0;
      r_owner        <= 1'b0;
      r_we           <= 1'b0;
      r_wdata        <= c_zero;
      r_to_cnt       <= '0;
      r_ram_din      <= '0;
      r_ram_rx_valid <= 1'b0;
      r_rsp0_valid   <= 1'b0;
      r_rsp1_valid   <= 1'b0;
      r_rsp0_rdata   <= c_zero;
      r_rsp1_rdata   <= c_zero;
      r_rsp0_err     <= 1'b0;
      r_rsp1_err     <= 1'b0;
    end else begin
      // The response strobes are single-cycle pulses. The response data is held until the next response.
      r_rsp0_valid <= 1'b0;
      r_rsp1_valid <= 1'b0;
      if (w_done) begin
        if (r_owner) begin
          r_rsp1_valid <= 1'b1;
          r_rsp1_rdata <= w_done_rdata;
          r_rsp1_err   <= w_done_err;
        end else begin
          r_rsp0_valid <= 1'b1;
          r_rsp0_rdata <= w_done_rdata;
          r_rsp0_err   <= w_done_err;
        end
      end

      case (r_state)
        S_IDLE: begin
          if (w_grant0 || w_grant1) begin
            r_owner        <= w_grant1;
            r_we           <= w_sel_we;
            r_wdata        <= w_sel_wdata;
            r_rr_ptr       <= ~w_grant1;
            r_ram_din      <= {(w_sel_we ? c_op_waddr : c_op_raddr), w_sel_addr};
            r_ram_rx_valid <= 1'b1;
            r_state        <= S_CMD_ADDR;
          end
        end
        S_CMD_ADDR: begin
          r_ram_din <= {(r_we ? c_op_wdata : c_op_rdummy), (r_we ? r_wdata : c_zero)};
          r_state   <= S_CMD_DATA;
        end
        S_CMD_DATA: begin
          r_ram_rx_valid <= 1'b0;
          r_to_cnt       <= '0;
          r_state        <= r_we ? S_RESP : S_WAIT_TX;
        end
        S_WAIT_TX: begin
          if (w_done) begin
            r_state <= S_RESP;
          end else begin
            r_to_cnt <= r_to_cnt + TO_W'(1);
          end
        end
        S_RESP: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.req0_ready   = w_grant0;
  assign bus.req1_ready   = w_grant1;
  assign bus.rsp0_valid   = r_rsp0_valid;
  assign bus.rsp0_rdata   = r_rsp0_rdata;
  assign bus.rsp0_err     = r_rsp0_err;
  assign bus.rsp1_valid   = r_rsp1_valid;
  assign bus.rsp1_rdata   = r_rsp1_rdata;
  assign bus.rsp1_err     = r_rsp1_err;
  assign bus.ram_din      = r_ram_din;
  assign bus.ram_rx_valid = r_ram_rx_valid;
  assign bus.busy         = !w_idle;

endmodule
`default_nettype wire

// File: tb/tb_ram_access_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_ram_access_arbiter
// Brief    : Self-checking bench for ram_access_arbiter. It runs directed steps
//            and then randomized transactions. A transaction-level reference
//            (fairness pointer, memory image, fixed latencies) and a
//            behavioural RAM model sit beside the DUT.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ram_access_arbiter;

  localparam int TIMEOUT = 15;

  logic clk;
  logic rst_n;

  ram_access_arbiter_if #(.ADDR_SIZE(8)) bus ();

  ram_access_arbiter #(
    .ADDR_SIZE(8),
    .TIMEOUT  (TIMEOUT),
    .TO_W     (4)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference state: which port wins the next tie, and the expected RAM image
  bit         ref_rr;
  logic [7:0] ref_mem [256];

  // Behavioural RAM: it decodes the command stream and answers reads one cycle later
  logic [7:0] ram_mem [256];
  logic [7:0] cur_addr;
  logic       pend;
  logic       model_tx;
  logic [7:0] model_dout;
  logic       spur_tx;
  logic       suppress_tx;

  assign bus.ram_tx_valid = model_tx | spur_tx;
  assign bus.ram_dout     = model_dout;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model process
  initial begin
    model_tx   = 1'b0;
    model_dout = 8'h00;
    pend       = 1'b0;
    cur_addr   = 8'h00;
    forever begin
      @(posedge clk);
      #1;
      model_tx = 1'b0;
      if (pend && !suppress_tx) begin
        model_tx   = 1'b1;
        model_dout = ram_mem[cur_addr];
      end
      pend = 1'b0;
      if (bus.ram_rx_valid) begin
        case (bus.ram_din[9:8])
          2'b00, 2'b10: cur_addr = bus.ram_din[7:0];
          2'b01:        ram_mem[cur_addr] = bus.ram_din[7:0];
          default:      pend = 1'b1;
        endcase
      end
    end
  end

  // Watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete within 500000 time units");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "/ram_din"},  32'(bus.ram_din), 32'h0);
    check({tag, "/rx_valid"}, 32'(bus.ram_rx_valid), 32'h0);
    check({tag, "/rsp0_v"},   32'(bus.rsp0_valid), 32'h0);
    check({tag, "/rsp1_v"},   32'(bus.rsp1_valid), 32'h0);
    check({tag, "/rdata"},    {16'h0, bus.rsp0_rdata, bus.rsp1_rdata}, 32'h0);
    check({tag, "/err"},      {30'h0, bus.rsp0_err, bus.rsp1_err}, 32'h0);
    check({tag, "/busy"},     32'(bus.busy), 32'h0);
  endtask

  // Runs one arbitration round from IDLE with the given requests and checks the full transaction
  task automatic run_txn(input bit v0, input bit we0, input logic [7:0] a0, input logic [7:0] d0,
                         input bit v1, input bit we1, input logic [7:0] a1, input logic [7:0] d1,
                         input bit spur, input string tag);
    bit         own;
    bit         we;
    logic [7:0] a;
    logic [7:0] d;
    logic [7:0] exp_rd;
    bit         exp_err;
    int         lat;
    int         exp_lat;
    bit         got;

    own = (v0 && v1) ? ref_rr : v1;
    we  = own ? we1 : we0;
    a   = own ? a1  : a0;
    d   = own ? d1  : d0;

    bus.req0_valid = v0; bus.req0_we = we0; bus.req0_addr = a0; bus.req0_wdata = d0;
    bus.req1_valid = v1; bus.req1_we = we1; bus.req1_addr = a1; bus.req1_wdata = d1;
    spur_tx = spur;
    #1;
    check({tag, "/ready0"}, 32'(bus.req0_ready), 32'(!own));
    check({tag, "/ready1"}, 32'(bus.req1_ready), 32'(own));

    // Cycle 1: address command. The loser stays valid and must remain stalled.
    step();
    ref_rr = !own;
    if (own) bus.req1_valid = 1'b0; else bus.req0_valid = 1'b0;
    check({tag, "/din_addr"}, 32'(bus.ram_din), 32'({(we ? 2'b00 : 2'b10), a}));
    check({tag, "/rx_addr"},  32'(bus.ram_rx_valid), 32'h1);
    check({tag, "/busy"},     32'(bus.busy), 32'h1);
    #1;
    check({tag, "/ready_busy"}, {30'h0, bus.req0_ready, bus.req1_ready}, 32'h0);

    // Cycle 2: data command
    step();
    spur_tx = 1'b0;
    check({tag, "/din_data"}, 32'(bus.ram_din), 32'({(we ? 2'b01 : 2'b11), (we ? d : 8'h00)}));
    check({tag, "/rx_data"},  32'(bus.ram_rx_valid), 32'h1);

    exp_err = !we && suppress_tx;
    exp_rd  = (we || suppress_tx) ? 8'h00 : ref_mem[a];
    exp_lat = we ? 3 : (suppress_tx ? 3 + TIMEOUT : 4);
    if (we) ref_mem[a] = d;

    lat = 2;
    got = 1'b0;
    while (!got && lat < 40) begin
      step();
      lat++;
      got = bus.rsp0_valid || bus.rsp1_valid;
    end
    check({tag, "/latency"}, 32'(lat), 32'(exp_lat));
    check({tag, "/rsp_own"},   32'(own ? bus.rsp1_valid : bus.rsp0_valid), 32'h1);
    check({tag, "/rsp_other"}, 32'(own ? bus.rsp0_valid : bus.rsp1_valid), 32'h0);
    check({tag, "/rdata"},     32'(own ? bus.rsp1_rdata : bus.rsp0_rdata), 32'(exp_rd));
    check({tag, "/err"},       32'(own ? bus.rsp1_err   : bus.rsp0_err),   32'(exp_err));
    check({tag, "/rx_idle"},   32'(bus.ram_rx_valid), 32'h0);

    // The cycle after the response is IDLE, and the response data is still held
    step();
    check({tag, "/rsp_clear"}, {30'h0, bus.rsp0_valid, bus.rsp1_valid}, 32'h0);
    check({tag, "/idle"},      32'(bus.busy), 32'h0);
    check({tag, "/rdata_hold"}, 32'(own ? bus.rsp1_rdata : bus.rsp0_rdata), 32'(exp_rd));
  endtask

  initial begin
    bit         v0;
    bit         v1;
    logic [1:0] pat;
    logic [7:0] ra0;
    logic [7:0] ra1;

    for (int i = 0; i < 256; i++) begin
      ram_mem[i] = 8'(i * 7 + 3);
      ref_mem[i] = ram_mem[i];
    end
    ref_rr      = 1'b0;
    spur_tx     = 1'b0;
    suppress_tx = 1'b0;
    bus.req0_valid = 1'b0; bus.req0_we = 1'b0; bus.req0_addr = 8'h00; bus.req0_wdata = 8'h00;
    bus.req1_valid = 1'b0; bus.req1_we = 1'b0; bus.req1_addr = 8'h00; bus.req1_wdata = 8'h00;

    // Reset state
    rst_n = 1'b0;
    step(); step(); step();
    check_all_zero("reset");
    check("reset/ready", {30'h0, bus.req0_ready, bus.req1_ready}, 32'h0);
    rst_n = 1'b1;
    step();

    // Port 0 write to FE, then port 1 reads it back
    run_txn(1, 1, 8'hFE, 8'hA5, 0, 0, 8'h00, 8'h00, 0, "p0_write");
    run_txn(0, 0, 8'h00, 8'h00, 1, 0, 8'hFE, 8'h00, 0, "p1_read");

    // Both requesters held valid: the grants alternate 0,1,0,1
    for (int k = 0; k < 4; k++) begin
      check("alt/ptr_pred", 32'(ref_rr), 32'(k % 2));
      run_txn(1, 1'(k % 2), 8'(k * 3), 8'(8'h30 + k), 1, 1'((k + 1) % 2), 8'(k * 5 + 1), 8'(8'h60 + k), 0, "alternate");
    end

    // Read timeout: the RAM never answers
    suppress_tx = 1'b1;
    run_txn(1, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0, "timeout");
    suppress_tx = 1'b0;

    // Address boundaries pass through unchanged
    run_txn(0, 1, 8'h00, 8'h00, 1, 1, 8'hFF, 8'h3C, 0, "addr_ff_wr");
    run_txn(1, 0, 8'hFF, 8'h00, 0, 0, 8'h00, 8'h00, 0, "addr_ff_rd");
    run_txn(0, 0, 8'h00, 8'h00, 1, 0, 8'h00, 8'h00, 0, "addr_00_rd");

    // A spurious tx_valid while idle is ignored
    spur_tx = 1'b1;
    step(); step();
    spur_tx = 1'b0;
    check("spur_idle/rsp", {30'h0, bus.rsp0_valid, bus.rsp1_valid}, 32'h0);
    check("spur_idle/busy", 32'(bus.busy), 32'h0);
    run_txn(1, 0, 8'h42, 8'h00, 0, 0, 8'h00, 8'h00, 1, "spur_cmd");

    // A request valid that is dropped before it is granted starts nothing
    bus.req1_valid = 1'b1; bus.req1_we = 1'b1;
    bus.req0_valid = 1'b0;
    #1;
    bus.req1_valid = 1'b0;
    step();
    check("drop/busy", 32'(bus.busy), 32'h0);

    // Reset during CMD_DATA: outputs clear immediately, no response, pointer returns to port 0
    run_txn(1, 1, 8'h10, 8'h77, 0, 0, 8'h00, 8'h00, 0, "pre_reset");
    bus.req0_valid = 1'b1; bus.req0_we = 1'b0; bus.req0_addr = 8'h10;
    step();
    bus.req0_valid = 1'b0;
    step();
    check("rst_mid/in_data", {30'h0, bus.ram_din[9:8]}, 32'h3);
    #1;
    rst_n = 1'b0;
    #1;
    check_all_zero("rst_mid");
    step(); step();
    check_all_zero("rst_hold");
    rst_n = 1'b1;
    ref_rr = 1'b0;
    step(); step(); step();
    check("rst_after/rsp", {30'h0, bus.rsp0_valid, bus.rsp1_valid}, 32'h0);
    check("rst_after/busy", 32'(bus.busy), 32'h0);
    run_txn(1, 0, 8'h10, 8'h00, 1, 0, 8'h20, 8'h00, 0, "post_reset_tie");

    // Randomized traffic
    for (int n = 0; n < 40; n++) begin
      pat = 2'($urandom_range(1, 3));
      v0  = pat[0];
      v1  = pat[1];
      ra0 = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 1) * 255) : 8'($urandom_range(0, 15));
      ra1 = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 1) * 255) : 8'($urandom_range(0, 15));
      suppress_tx = ($urandom_range(0, 9) == 0);
      run_txn(v0, 1'($urandom_range(0, 1)), ra0, 8'($urandom_range(0, 255)),
              v1, 1'($urandom_range(0, 1)), ra1, 8'($urandom_range(0, 255)),
              1'($urandom_range(0, 1)), "random");
      suppress_tx = 1'b0;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
